// File: rtl/alu_shift_pkg.sv
// Shared encodings for the iterative shift/rotate unit: operation modes and FSM states.
package alu_shift_pkg;

    typedef enum logic [2:0] {
        MODE_SHL = 3'd0,
        MODE_SHR = 3'd1,
        MODE_SAR = 3'd2,
        MODE_ROL = 3'd3,
        MODE_ROR = 3'd4
    } shift_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } shift_state_e;

endpackage : alu_shift_pkg

// File: rtl/alu_shift_step.sv
// Single one-bit shift/rotate step; cf is the bit that leaves (or wraps around) r.
module alu_shift_step
    import alu_shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] r_nxt_c,
    output logic             cf_nxt_c
);

    always_comb begin
        r_nxt_c  = r;
        cf_nxt_c = 1'b0;
        case (mode)
            MODE_SHL: begin
                r_nxt_c  = {r[WIDTH-2:0], 1'b0};
                cf_nxt_c = r[WIDTH-1];
            end
            MODE_SHR: begin
                r_nxt_c  = {1'b0, r[WIDTH-1:1]};
                cf_nxt_c = r[0];
            end
            MODE_SAR: begin
                r_nxt_c  = {r[WIDTH-1], r[WIDTH-1:1]};
                cf_nxt_c = r[0];
            end
            // Rotates report the bit that wrapped, i.e. the new end bit.
            MODE_ROL: begin
                r_nxt_c  = {r[WIDTH-2:0], r[WIDTH-1]};
                cf_nxt_c = r[WIDTH-1];
            end
            MODE_ROR: begin
                r_nxt_c  = {r[0], r[WIDTH-1:1]};
                cf_nxt_c = r[0];
            end
            default: begin
                r_nxt_c  = r;
                cf_nxt_c = 1'b0;
            end
        endcase
    end

endmodule : alu_shift_step

// File: rtl/alu_shift_unit.sv
// Multi-cycle shift/rotate unit: accepts an operand in IDLE, steps one bit per clock,
// then holds the result in DONE until the consumer takes it.
module alu_shift_unit
    import alu_shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic             cf,
    output logic             zf
);

    localparam int unsigned SHAMT_W = $clog2(WIDTH) + 1;
    localparam int unsigned CNT_W   = $clog2(WIDTH + 2);

    shift_state_e     state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             cf_q, cf_d;
    logic             zf_q, zf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       mode_q, mode_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;

    logic [SHAMT_W-1:0] n_c;
    logic [CNT_W-1:0]   cnt_load_c;
    logic [WIDTH-1:0]   step_r_c;
    logic               step_cf_c;
    logic               b_unused;

    // Only the low SHAMT_W bits of b carry the shift amount.
    assign n_c      = b[SHAMT_W-1:0];
    assign b_unused = ^b;

    // Shifts saturate at WIDTH+1 steps (enough to clear cf too); rotates wrap.
    always_comb begin
        int unsigned n_u;
        n_u        = 32'(n_c);
        cnt_load_c = '0;
        case (mode)
            MODE_SHL, MODE_SHR, MODE_SAR:
                cnt_load_c = CNT_W'((n_u > WIDTH + 1) ? WIDTH + 1 : n_u);
            MODE_ROL, MODE_ROR:
                cnt_load_c = CNT_W'(n_u % WIDTH);
            default:
                cnt_load_c = '0;
        endcase
    end

    alu_shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .mode     (mode_q),
        .r        (r_q),
        .r_nxt_c  (step_r_c),
        .cf_nxt_c (step_cf_c)
    );

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        cf_d        = cf_q;
        zf_d        = zf_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    r_d     = a;
                    cf_d    = 1'b0;
                    zf_d    = (a == '0);
                    cnt_d   = cnt_load_c;
                    mode_d  = mode;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    r_d   = step_r_c;
                    cf_d  = step_cf_c;
                    zf_d  = (step_r_c == '0);
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort wins over everything but leaves the visible result untouched.
        if (flush) begin
            state_d = ST_IDLE;
            r_d     = r_q;
            cf_d    = cf_q;
            zf_d    = zf_q;
            cnt_d   = cnt_q;
            mode_d  = mode_q;
        end

        out_valid_d = (state_d == ST_DONE);
        in_ready_d  = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            r_q         <= '0;
            cf_q        <= 1'b0;
            zf_q        <= 1'b0;
            cnt_q       <= '0;
            mode_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            cf_q        <= cf_d;
            zf_q        <= zf_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign r         = r_q;
    assign cf        = cf_q;
    assign zf        = zf_q;

endmodule : alu_shift_unit

// File: tb/tb_alu_shift_unit.sv
// Self-checking bench for alu_shift_unit (WIDTH=8) with an arithmetic reference model.
module tb_alu_shift_unit;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] mode;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] r;
    logic       cf;
    logic       zf;

    int n_cmp = 0;
    int n_err = 0;

    alu_shift_unit #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r),
        .cf        (cf),
        .zf        (zf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: whole-operation result computed directly from the shift amount.
    function automatic logic [8:0] ref_op(input logic [2:0] m, input logic [7:0] av, input int n);
        logic [31:0]        x;
        logic signed [31:0] s;
        logic [7:0]         rr;
        logic               cc;
        int                 k;
        k = n % 8;
        rr = av;
        cc = 1'b0;
        case (m)
            3'd0: begin x = 32'(av) << n; rr = x[7:0]; cc = x[8]; end
            3'd1: begin x = {16'h0, av, 8'h0} >> n; rr = x[15:8]; cc = x[7]; end
            3'd2: begin s = {{16{av[7]}}, av, 8'h0}; s = s >>> n; rr = s[15:8]; cc = s[7]; end
            3'd3: begin x = {16'h0, av, av} << k; rr = x[15:8]; cc = (k != 0) ? rr[0] : 1'b0; end
            3'd4: begin x = {16'h0, av, av} >> k; rr = x[7:0]; cc = (k != 0) ? rr[7] : 1'b0; end
            default: begin rr = av; cc = 1'b0; end
        endcase
        return {cc, rr};
    endfunction

    function automatic int ref_lat(input logic [2:0] m, input int n);
        if (m <= 3'd2) return ((n > 9) ? 9 : n) + 1;
        if (m <= 3'd4) return (n % 8) + 1;
        return 1;
    endfunction

    // Issue one operation, measure edges from acceptance to out_valid, then retire it.
    task automatic do_op(input logic [2:0] m, input logic [7:0] av, input logic [7:0] bv,
                         output logic [7:0] ro, output logic cfo, output logic zfo,
                         output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b1; mode = m; a = av; b = bv;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
        end
        ro = r; cfo = cf; zfo = zf;
        @(negedge clk) out_ready = 1'b1;
        @(negedge clk) out_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({in_ready, out_valid, r, cf, zf} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset: got rdy=%b ov=%b r=%h cf=%b zf=%b, want 1 0 00 0 0",
                     in_ready, out_valid, r, cf, zf);
        end
    endtask

    task automatic test_directed();
        logic [2:0] tm [7] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd4};
        logic [7:0] tb_ [7] = '{8'd1, 8'd8, 8'd9, 8'd3, 8'd15, 8'd11, 8'd8};
        logic [7:0] er [7] = '{8'h2C, 8'h00, 8'h00, 8'hF2, 8'hFF, 8'hB4, 8'h96};
        logic       ec [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        int         el [7] = '{2, 9, 10, 4, 10, 4, 1};
        logic [7:0] ro;
        logic       cfo, zfo;
        int         lat;
        for (int i = 0; i < 7; i++) begin
            do_op(tm[i], 8'h96, tb_[i], ro, cfo, zfo, lat);
            n_cmp++;
            if ({ro, cfo, zfo} !== {er[i], ec[i], er[i] == 8'h00} || lat != el[i]) begin
                n_err++;
                $display("FAIL directed[%0d]: got r=%h cf=%b zf=%b lat=%0d, want r=%h cf=%b zf=%b lat=%0d",
                         i, ro, cfo, zfo, lat, er[i], ec[i], er[i] == 8'h00, el[i]);
            end
        end
        do_op(3'd6, 8'h96, 8'd5, ro, cfo, zfo, lat);
        n_cmp++;
        if ({ro, cfo, zfo} !== {8'h96, 1'b0, 1'b0} || lat != 1) begin
            n_err++;
            $display("FAIL illegal_mode: got r=%h cf=%b zf=%b lat=%0d, want 96 0 0 1", ro, cfo, zfo, lat);
        end
    endtask

    task automatic test_random();
        logic [2:0] m;
        logic [7:0] av, bv, ro;
        logic       cfo, zfo;
        logic [8:0] exp_v;
        int         lat, el;
        for (int i = 0; i < 80; i++) begin
            m  = 3'($urandom_range(0, 7));
            av = 8'($urandom);
            bv = 8'($urandom);
            if (i % 10 == 0) av = 8'h00;
            exp_v = ref_op(m, av, int'(bv[3:0]));
            el    = ref_lat(m, int'(bv[3:0]));
            do_op(m, av, bv, ro, cfo, zfo, lat);
            n_cmp++;
            if ({ro, cfo, zfo} !== {exp_v[7:0], exp_v[8], exp_v[7:0] == 8'h00} || lat != el) begin
                n_err++;
                $display("FAIL random[%0d] m=%0d a=%h b=%h: got r=%h cf=%b zf=%b lat=%0d, want r=%h cf=%b zf=%b lat=%0d",
                         i, m, av, bv, ro, cfo, zfo, lat, exp_v[7:0], exp_v[8], exp_v[7:0] == 8'h00, el);
            end
        end
    endtask

    task automatic test_hold();
        logic [7:0] ro;
        logic       cfo, zfo;
        int         lat;
        int         guard;
        @(negedge clk);
        in_valid = 1'b1; mode = 3'd0; a = 8'h96; b = 8'd2;
        @(negedge clk);
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (guard >= 40) begin
            n_err++;
            $display("FAIL hold_timeout: out_valid never rose");
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; a = 8'($urandom); b = 8'd1; mode = 3'd1;
            @(negedge clk);
            n_cmp++;
            if ({out_valid, in_ready, r, cf, zf} !== {1'b1, 1'b0, 8'h58, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL hold[%0d]: got ov=%b rdy=%b r=%h cf=%b zf=%b, want 1 0 58 0 0",
                         i, out_valid, in_ready, r, cf, zf);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk) out_ready = 1'b0;
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL hold_release: got ov=%b rdy=%b, want 0 1", out_valid, in_ready);
        end
        do_op(3'd4, 8'h01, 8'd1, ro, cfo, zfo, lat);
        n_cmp++;
        if ({ro, cfo, zfo} !== {8'h80, 1'b1, 1'b0} || lat != 2) begin
            n_err++;
            $display("FAIL hold_next: got r=%h cf=%b zf=%b lat=%0d, want 80 1 0 2", ro, cfo, zfo, lat);
        end
    endtask

    task automatic test_flush();
        int guard;
        // Flush in the third SHIFT cycle of SHL n=7; two steps done leaves r=58, cf=0.
        @(negedge clk);
        in_valid = 1'b1; mode = 3'd0; a = 8'h96; b = 8'd7;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_cmp++;
        if ({in_ready, out_valid, r, cf} !== {1'b1, 1'b0, 8'h58, 1'b0}) begin
            n_err++;
            $display("FAIL flush_shift: got rdy=%b ov=%b r=%h cf=%b, want 1 0 58 0", in_ready, out_valid, r, cf);
        end
        repeat (12) @(negedge clk);
        n_cmp++;
        if ({out_valid, r} !== {1'b0, 8'h58}) begin
            n_err++;
            $display("FAIL flush_quiet: got ov=%b r=%h, want 0 58", out_valid, r);
        end
        // Flush coinciding with an acceptance drops the request.
        in_valid = 1'b1; flush = 1'b1; a = 8'h11; b = 8'd0; mode = 3'd0;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({in_ready, out_valid, r} !== {1'b1, 1'b0, 8'h58}) begin
            n_err++;
            $display("FAIL flush_accept: got rdy=%b ov=%b r=%h, want 1 0 58", in_ready, out_valid, r);
        end
        // Flush in DONE drops out_valid and keeps the result.
        in_valid = 1'b1; a = 8'h40; b = 8'd1; mode = 3'd0;
        @(negedge clk);
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_cmp++;
        if ({out_valid, in_ready, r, cf, zf} !== {1'b0, 1'b1, 8'h80, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL flush_done: got ov=%b rdy=%b r=%h cf=%b zf=%b, want 0 1 80 0 0",
                     out_valid, in_ready, r, cf, zf);
        end
        // Asynchronous reset mid-shift clears outputs without waiting for an edge.
        in_valid = 1'b1; mode = 3'd0; a = 8'h96; b = 8'd7;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, out_valid, r, cf, zf} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_mid: got rdy=%b ov=%b r=%h cf=%b zf=%b, want 1 0 00 0 0",
                     in_ready, out_valid, r, cf, zf);
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (12) @(negedge clk);
        n_cmp++;
        if ({out_valid, in_ready, r} !== {1'b0, 1'b1, 8'h00}) begin
            n_err++;
            $display("FAIL reset_quiet: got ov=%b rdy=%b r=%h, want 0 1 00", out_valid, in_ready, r);
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        mode = 3'd0; a = 8'h00; b = 8'h00;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_directed();
        test_random();
        test_hold();
        test_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_alu_shift_unit
